// File: rtl/mem_arbiter.sv
// Purpose: arbitrates an instruction-fetch port and a data port onto one single-outstanding memory port.
// Latency: grant on the edge after req, done pulses in the cycle after mem_ready (2 cycles minimum req-to-done).
// Backpressure: requesters hold req until done; memory stalls with mem_ready (optional abort: MEM_ARB_TIMEOUT_EN).
module mem_arbiter #(
    parameter int STARVE_LIMIT   = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_done,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    input  logic [3:0]  dm_be,
    output logic [31:0] dm_rdata,
    output logic        dm_done,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        err
);

    // Starvation counter is at least 3 bits wide and must reach STARVE_LIMIT
    localparam int SW = ($clog2(STARVE_LIMIT + 1) < 3) ? 3 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        DM_BUSY = 2'd2,
        RESP    = 2'd3
    } state_t;

    // Latched access; only the word address is kept since memory is word-aligned
    typedef struct packed {
        logic        we;
        logic [29:0] waddr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } acc_t;

    state_t        state;
    state_t        state_nxt;
    acc_t          acc;
    logic          owner_dm;
    logic [SW-1:0] starve_cnt;
    logic          busy;
    logic          dm_grant;
    logic          if_grant;
    logic          timeout;
    logic          mem_done;
    logic [31:0]   rdata_in;
    logic          unused_addr_bits;

    assign unused_addr_bits = ^{if_addr[1:0], dm_addr[1:0]};

    assign busy      = (state == IF_BUSY) || (state == DM_BUSY);
    assign mem_done  = busy && (mem_ready || timeout);
    assign rdata_in  = timeout ? 32'hDEADBEEF : mem_rdata;
    assign mem_addr  = {acc.waddr, 2'b00};
    assign mem_wdata = acc.wdata;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] busy_cnt;
    logic          err_q;

    assign timeout = busy && !mem_ready && (busy_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign err     = err_q;

    // Count consecutive stalled BUSY cycles; err_q marks the RESP cycle of an aborted access
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            err_q <= timeout;
            if (busy && !mem_ready && !timeout) begin
                busy_cnt <= busy_cnt + 1'b1;
            end else begin
                busy_cnt <= '0;
            end
        end
    end
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Arbitration, next state and memory/done outputs
    always_comb begin
        state_nxt = state;
        dm_grant  = 1'b0;
        if_grant  = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_be    = 4'h0;
        if_done   = 1'b0;
        dm_done   = 1'b0;
        case (state)
            IDLE: begin
                dm_grant = dm_req && (!if_req || (starve_cnt < STARVE_MAX));
                if_grant = if_req && (!dm_req || (starve_cnt == STARVE_MAX));
                if (dm_grant) begin
                    state_nxt = DM_BUSY;
                end else if (if_grant) begin
                    state_nxt = IF_BUSY;
                end
            end
            IF_BUSY, DM_BUSY: begin
                mem_en = 1'b1;
                mem_we = acc.we;
                mem_be = acc.be;
                if (mem_done) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if_done   = !owner_dm;
                dm_done   = owner_dm;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Latch the granted request and capture read data for loads and fetches
    always_ff @(posedge clk) begin
        if (rst) begin
            acc      <= '0;
            owner_dm <= 1'b0;
            if_rdata <= 32'h0;
            dm_rdata <= 32'h0;
        end else begin
            if (dm_grant) begin
                acc.we    <= dm_we;
                acc.waddr <= dm_addr[31:2];
                acc.wdata <= dm_wdata;
                acc.be    <= dm_be;
                owner_dm  <= 1'b1;
            end else if (if_grant) begin
                acc.we    <= 1'b0;
                acc.waddr <= if_addr[31:2];
                acc.be    <= 4'hF;
                owner_dm  <= 1'b0;
            end
            if (mem_done && !acc.we) begin
                if (state == DM_BUSY) begin
                    dm_rdata <= rdata_in;
                end else begin
                    if_rdata <= rdata_in;
                end
            end
        end
    end

    // Data grants taken while a fetch waits; cleared once the fetch wins or stops asking
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (state == IDLE) begin
            if (!if_req || if_grant) begin
                starve_cnt <= '0;
            end else if (dm_grant && (starve_cnt != STARVE_MAX)) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus concurrent random fetch/data traffic.
// A memory responder with programmable wait states stands in for the memory.
// Expected responses are queued at issue and checked by a monitor on every done pulse.
module tb_mem_arbiter;

    localparam int SL = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_be;
    logic [31:0] dm_rdata;
    logic        dm_done;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        mem_ready = 1'b0;
    logic        err;

    mem_arbiter #(.STARVE_LIMIT(SL), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_be(dm_be), .dm_rdata(dm_rdata), .dm_done(dm_done),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        store;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    exp_t        if_q[$];
    exp_t        dm_q[$];
    logic        grant_q[$];
    logic [31:0] ref_mem [0:2047];
    logic [31:0] mem_arr [0:2047];
    logic [31:0] m_if_rdata = 32'h0;
    logic [31:0] m_dm_rdata = 32'h0;
    string       done_log = "";
    int          fixed_wait = -1;
    bit          ready_noise = 1'b1;
    int          last_we_cycles = 0;
    logic [31:0] last_addr = 32'h0;

    assign mem_rdata = mem_arr[mem_addr[12:2]];

    function automatic logic [31:0] init_word(input int i);
        return (32'(i) * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_str(input string name, input string act, input string exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got \"%s\" expected \"%s\"", name, act, exp);
        end
    endtask

    task automatic bad(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: event missing or unexpected", name);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic if_issue(input logic [31:0] a, input logic experr, output int lat);
        exp_t e;
        e.store = 1'b0;
        e.err   = experr;
        e.rdata = experr ? 32'hDEADBEEF : ref_mem[a[12:2]];
        if_q.push_back(e);
        if_addr = a;
        if_req  = 1'b1;
        lat = 0;
        do begin
            step(1);
            lat++;
        end while (!if_done && lat < 200);
        if (!if_done) bad("if_done_wait");
        if_req = 1'b0;
    endtask

    task automatic dm_issue(input logic we, input logic [31:0] a, input logic [31:0] wd,
                            input logic [3:0] be, input logic experr, output int lat);
        exp_t        e;
        logic [31:0] w;
        e.store = we;
        e.err   = experr;
        e.rdata = 32'h0;
        if (we) begin
            if (!experr) begin
                w = ref_mem[a[12:2]];
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) w[8*b +: 8] = wd[8*b +: 8];
                end
                ref_mem[a[12:2]] = w;
            end
        end else begin
            e.rdata = experr ? 32'hDEADBEEF : ref_mem[a[12:2]];
        end
        dm_q.push_back(e);
        dm_we    = we;
        dm_addr  = a;
        dm_wdata = wd;
        dm_be    = be;
        dm_req   = 1'b1;
        lat = 0;
        do begin
            step(1);
            lat++;
        end while (!dm_done && lat < 200);
        if (!dm_done) bad("dm_done_wait");
        dm_req = 1'b0;
    endtask

    // Memory responder: programmable wait states, stores applied on the ready cycle
    initial begin
        int wcnt;
        int wtarget;
        int cur_we;
        wcnt = 0;
        wtarget = 0;
        cur_we = 0;
        forever begin
            @(negedge clk);
            if (mem_en) begin
                if (wcnt == 0) wtarget = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 3));
                chk("mem_addr_align", {30'b0, mem_addr[1:0]}, 32'h0);
                if (mem_we) cur_we++;
                mem_ready = (wcnt >= wtarget);
                if (mem_ready) begin
                    last_we_cycles = cur_we;
                    last_addr      = mem_addr;
                    if (mem_we) begin
                        for (int b = 0; b < 4; b++) begin
                            if (mem_be[b]) mem_arr[mem_addr[12:2]][8*b +: 8] = mem_wdata[8*b +: 8];
                        end
                    end
                end
                wcnt++;
            end else begin
                chk("idle_mem_we_be", {27'b0, mem_we, mem_be}, 32'h0);
                wcnt   = 0;
                cur_we = 0;
                mem_ready = ready_noise ? 1'($urandom_range(0, 1)) : 1'b0;
            end
        end
    end

    // Monitor: arbitration reference and response scoreboard
    initial begin
        int   starve_m;
        logic prev_idle;
        logic expect_start;
        logic g;
        exp_t e;
        starve_m = 0;
        prev_idle = 1'b0;
        expect_start = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                starve_m = 0;
                grant_q.delete();
                prev_idle = 1'b0;
                expect_start = 1'b0;
                m_if_rdata = 32'h0;
                m_dm_rdata = 32'h0;
            end else begin
                if (prev_idle) chk("grant_start", 32'(mem_en), 32'(expect_start));
                prev_idle = !mem_en && !if_done && !dm_done;
                expect_start = 1'b0;
                if (prev_idle) begin
                    if (dm_req && (!if_req || starve_m < SL)) begin
                        grant_q.push_back(1'b1);
                        expect_start = 1'b1;
                        if (if_req) starve_m = (starve_m < SL) ? starve_m + 1 : SL;
                    end else if (if_req) begin
                        grant_q.push_back(1'b0);
                        expect_start = 1'b1;
                        starve_m = 0;
                    end
                    if (!if_req) starve_m = 0;
                end
                if (if_done || dm_done) begin
                    chk("single_done", 32'(if_done & dm_done), 32'h0);
                    if (grant_q.size() == 0) begin
                        bad("done_without_grant");
                    end else begin
                        g = grant_q.pop_front();
                        chk("grant_owner", 32'(dm_done), 32'(g));
                    end
                    if (dm_done) begin
                        done_log = {done_log, "D"};
                        if (dm_q.size() == 0) begin
                            bad("dm_done_unexpected");
                        end else begin
                            e = dm_q.pop_front();
                            if (!e.store) m_dm_rdata = e.rdata;
                            chk("dm_err", 32'(err), 32'(e.err));
                        end
                    end else begin
                        done_log = {done_log, "I"};
                        if (if_q.size() == 0) begin
                            bad("if_done_unexpected");
                        end else begin
                            e = if_q.pop_front();
                            m_if_rdata = e.rdata;
                            chk("if_err", 32'(err), 32'(e.err));
                        end
                    end
                    chk("if_rdata", if_rdata, m_if_rdata);
                    chk("dm_rdata", dm_rdata, m_dm_rdata);
                end
            end
        end
    end

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

    // Stimulus
    initial begin
        int lat;
        int lat_a;
        int lat_b;
        int n;
        logic saw;
        for (int i = 0; i < 2048; i++) begin
            ref_mem[i] = init_word(i);
            mem_arr[i] = init_word(i);
        end
        rst = 1'b1;
        if_req = 1'b0;
        if_addr = 32'h0;
        dm_req = 1'b0;
        dm_we = 1'b0;
        dm_addr = 32'h0;
        dm_wdata = 32'h0;
        dm_be = 4'h0;
        step(3);
        chk("rst_mem_en", 32'(mem_en), 32'h0);
        chk("rst_mem_we", 32'(mem_we), 32'h0);
        chk("rst_mem_be", 32'(mem_be), 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_if_rdata", if_rdata, 32'h0);
        chk("rst_dm_rdata", dm_rdata, 32'h0);
        chk("rst_dones", {30'b0, if_done, dm_done}, 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        rst = 1'b0;

        // Zero-wait fetch
        fixed_wait = 0;
        mem_arr[1] = 32'h00A00093;
        ref_mem[1] = 32'h00A00093;
        if_issue(32'h0000_0006, 1'b0, lat);
        chk("zw_fetch_latency", lat, 32'd2);
        chk("zw_fetch_mem_addr", last_addr, 32'h4);
        chk("zw_fetch_if_rdata", if_rdata, 32'h00A00093);
        step(1);

        // Simultaneous requests: data first, fetch next
        fixed_wait = -1;
        done_log = "";
        fork
            if_issue(32'h1000, 1'b0, lat_a);
            dm_issue(1'b0, 32'h20, 32'h0, 4'h0, 1'b0, lat_b);
        join
        step(1);
        chk_str("simul_order", done_log, "DI");

        // Data held continuously: fetch gets in after every STARVE_LIMIT data grants
        done_log = "";
        fork
            begin
                if_issue(32'h1100, 1'b0, lat_a);
                if_issue(32'h1104, 1'b0, lat_a);
            end
            begin
                for (int i = 0; i < 9; i++) dm_issue(1'b0, 32'(i * 4), 32'h0, 4'h0, 1'b0, lat_b);
            end
        join
        step(1);
        chk_str("starve_order", done_log, "DDDDIDDDDID");

        // Store with 3 wait states
        fixed_wait = 3;
        dm_issue(1'b1, 32'h10, 32'h64, 4'hF, 1'b0, lat);
        chk("store_latency", lat, 32'd5);
        chk("store_we_cycles", last_we_cycles, 32'd4);
        chk("store_mem_addr", last_addr, 32'h10);
        chk("store_dm_rdata_hold", dm_rdata, m_dm_rdata);
        step(1);

        // Reset mid-DM_BUSY with starve count at its limit and a fetch still pending
        fixed_wait = -1;
        if_addr = 32'h1000;
        if_req = 1'b1;
        for (int i = 0; i < 3; i++) dm_issue(1'b0, 32'h30, 32'h0, 4'h0, 1'b0, lat_b);
        fixed_wait = 1000;
        dm_we = 1'b0;
        dm_addr = 32'h40;
        dm_req = 1'b1;
        n = 0;
        do begin
            step(1);
            n++;
        end while (!mem_en && n < 10);
        if (!mem_en) bad("rst_test_busy_wait");
        step(2);
        rst = 1'b1;
        step(1);
        chk("rst_busy_mem_en", 32'(mem_en), 32'h0);
        chk("rst_busy_no_done", 32'(dm_done), 32'h0);
        chk("rst_busy_mem_addr", mem_addr, 32'h0);
        rst = 1'b0;
        dm_req = 1'b0;
        fixed_wait = -1;
        done_log = "";
        fork
            if_issue(32'h1004, 1'b0, lat_a);
            dm_issue(1'b0, 32'h10, 32'h0, 4'h0, 1'b0, lat_b);
        join
        step(1);
        chk_str("post_rst_order", done_log, "DI");
        chk("store_readback", dm_rdata, 32'h64);

`ifdef MEM_ARB_TIMEOUT_EN
        fixed_wait = 1000;
        dm_issue(1'b0, 32'h44, 32'h0, 4'h0, 1'b1, lat);
        chk("timeout_latency", lat, 32'd17);
        chk("timeout_dm_rdata", dm_rdata, 32'hDEADBEEF);
        fixed_wait = -1;
        step(1);
`endif

        // Random concurrent traffic
        fixed_wait = -1;
        fork
            begin
                for (int i = 0; i < 30; i++) begin
                    step(int'($urandom_range(0, 3)));
                    if_issue(32'h1000 | {20'b0, 10'($urandom_range(0, 1023)), 2'($urandom_range(0, 3))},
                             1'b0, lat_a);
                end
            end
            begin
                for (int i = 0; i < 50; i++) begin
                    step(int'($urandom_range(0, 3)));
                    dm_issue(1'($urandom_range(0, 1)),
                             {26'b0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))},
                             $urandom, 4'($urandom_range(0, 15)), 1'b0, lat_b);
                end
            end
        join
        step(5);
        chk("if_q_drained", if_q.size(), 32'd0);
        chk("dm_q_drained", dm_q.size(), 32'd0);
        chk("grant_q_drained", grant_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: consecutive data grants allowed while a fetch is pending.
REQ-002 Parameter TIMEOUT_CYCLES, default 16: BUSY-cycle limit, used only under MEM_ARB_TIMEOUT_EN.
REQ-003 Port list (name  direction  width  meaning), which SHALL be exactly:
- clk  in  1  single clock; one clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- if_req  in  1  instruction-fetch request, held until if_done
- if_addr  in  32  fetch byte address
- if_rdata  out  32  fetched word
- if_done  out  1  fetch complete, 1-cycle pulse
- dm_req  in  1  data request, held until dm_done
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  32  data byte address
- dm_wdata  in  32  store data
- dm_be  in  4  store byte enables
- dm_rdata  out  32  load word
- dm_done  out  1  data complete, 1-cycle pulse
- mem_en  out  1  memory access active
- mem_we  out  1  memory write
- mem_addr  out  32  word-aligned address
- mem_wdata  out  32  memory write data
- mem_be  out  4  memory byte enables
- mem_rdata  in  32  memory read data
- mem_ready  in  1  memory completes access this cycle
- err  out  1  timeout abort flag; constant 0 without macro

Function
REQ-004 FSM states SHALL be IDLE, IF_BUSY, DM_BUSY, RESP.
REQ-005 IDLE, dm_req=1 and (if_req=0 or starve_cnt<STARVE_LIMIT) -> DM_BUSY; latch dm_we, dm_addr, dm_wdata, dm_be.
REQ-006 IDLE, if_req=1 and (dm_req=0 or starve_cnt==STARVE_LIMIT) -> IF_BUSY; latch if_addr; mem_we=0, mem_be=4'hF.
REQ-007 In IF_BUSY/DM_BUSY, mem_en SHALL be 1 and mem_* SHALL be driven from latched values only; mem_addr[1:0]=2'b00.
REQ-008 BUSY with mem_ready=1 at the edge -> RESP; a load or fetch registers mem_rdata into the owner's rdata output.
REQ-009 In RESP, the owner's done SHALL be 1 for exactly that cycle, mem_en=0; the next state SHALL be IDLE unconditionally, with no arbitration in RESP.
REQ-010 A requester SHALL deassert req by the cycle after its done; the minimum req-to-done latency with zero-wait memory SHALL be 2 cycles.
REQ-011 starve_cnt (3 bits minimum) SHALL increment on each DM grant while if_req=1, clear on each IF grant or whenever if_req=0 in IDLE, and saturate at STARVE_LIMIT.
REQ-012 dm_rdata SHALL be unchanged by stores; if_rdata and dm_rdata SHALL hold their value until overwritten.
REQ-013 mem_ready while in IDLE or RESP SHALL be ignored.
REQ-014 Outputs outside BUSY: mem_en=mem_we=0, mem_be=0; mem_addr and mem_wdata SHALL hold their last latched values.

Reset
REQ-015 With rst=1 at an edge: state=IDLE, starve_cnt=0, mem_en=mem_we=0, mem_be=0, mem_addr=mem_wdata=0, if_rdata=dm_rdata=0, if_done=dm_done=0, err=0.
REQ-016 rst during BUSY or RESP SHALL abort the access with no done pulse; the next access restarts from IDLE arbitration.

Configuration
REQ-017 With macro MEM_ARB_TIMEOUT_EN defined, a BUSY cycle counter SHALL run; after TIMEOUT_CYCLES consecutive BUSY cycles without mem_ready the FSM SHALL go to RESP, pulse the owner's done with err=1 for that cycle, and write rdata=32'hDEADBEEF for loads and fetches.
REQ-018 Without MEM_ARB_TIMEOUT_EN, BUSY SHALL wait indefinitely for mem_ready, no counter logic SHALL exist, and err SHALL be tied 0.

Verification
REQ-019 The bench SHALL cover the following directed scenarios:
- Zero-wait fetch: if_req with if_addr=0x0000_0006 and mem_rdata=0x00A00093 -> mem_addr=0x4, if_done 2 cycles after req, if_rdata=0x00A00093.
- Simultaneous if_req/dm_req, starve_cnt=0 -> DM first; IF granted in the IDLE after dm_done.
- dm_req held continuously with if_req pending, STARVE_LIMIT=4 -> exactly 4 DM grants, then an IF grant; starve_cnt then reads 0.
- Store with dm_addr=0x10, dm_wdata=0x64, dm_be=4'hF, mem_ready after 3 wait cycles -> mem_we=1 for 4 cycles, dm_done then, dm_rdata unchanged.
- rst asserted mid-DM_BUSY -> no dm_done, mem_en=0 on the next cycle, starve_cnt=0.
- MEM_ARB_TIMEOUT_EN with mem_ready held 0 -> dm_done with err=1 after 16 BUSY cycles, dm_rdata=0xDEADBEEF.
